ipl_memory_loader: RTL and testbench

IPL_MEMORY_LOADER -- requirements
Module: ipl_memory_loader

---
 rtl/ipl_memory_loader.sv | 135 +++++++++++++
 tb/tb_ipl_memory_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipl_memory_loader.sv
// Packs an 8-bit Avalon-ST byte stream into 32-bit little-endian IPL memory words, holding the boot CPU in reset meanwhile.
// One WRITE cycle follows the byte that completes a word (4 bytes per 5 cycles); in_ready drops during WRITE/DONE/IDLE.
module ipl_memory_loader #(
    parameter int ADDR_W    = 12,
    parameter int BASE_WORD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W+1:0] byte_count,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W+2:0] MAX_BYTES = {1'b1, {(ADDR_W+2){1'b0}}};

    logic [1:0]        state;
    logic [31:0]       word_buf;
    logic [3:0]        lane_en;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_ptr;
    logic [ADDR_W+1:0] remaining;

    logic        len_ok;
    logic        accept;
    logic        word_last;
    logic        write_go;
    logic [31:0] word_next;

    assign len_ok    = (byte_count != '0) && ({1'b0, byte_count} <= MAX_BYTES);
    assign accept    = in_ready && in_valid;
    assign word_last = (lane == 2'd3) || (remaining == (ADDR_W+2)'(1));
    assign word_next = word_buf | ({24'h000000, in_data} << {lane, 3'b000});

    // abort in the WRITE cycle suppresses the strobe so a partial word never lands
    assign write_go       = (state == S_WRITE) && !abort;
    assign mem_chipselect = write_go;
    assign mem_write      = write_go;
    assign mem_byteenable = write_go ? lane_en : 4'b0000;

    assign in_ready      = (state == S_LOAD);
    assign busy          = (state != S_IDLE);
    assign cpu_reset_req = (state != S_IDLE);
    assign done          = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            word_buf      <= '0;
            lane_en       <= '0;
            lane          <= '0;
            word_ptr      <= '0;
            remaining     <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
            error         <= 1'b0;
            checksum      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state     <= S_LOAD;
                            error     <= 1'b0;
                            checksum  <= '0;
                            word_ptr  <= ADDR_W'(BASE_WORD);
                            lane      <= '0;
                            lane_en   <= '0;
                            word_buf  <= '0;
                            remaining <= byte_count;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        error    <= 1'b1;
                        word_buf <= '0;
                        lane_en  <= '0;
                        lane     <= '0;
                    end else if (accept) begin
                        word_buf      <= word_next;
                        lane_en[lane] <= 1'b1;
                        lane          <= lane + 2'd1;
                        checksum      <= checksum + {8'h00, in_data};
                        remaining     <= remaining - (ADDR_W+2)'(1);
                        if (word_last) begin
                            state         <= S_WRITE;
                            mem_address   <= word_ptr;
                            mem_writedata <= word_next;
                        end
                    end
                end
                S_WRITE: begin
                    word_buf <= '0;
                    lane_en  <= '0;
                    lane     <= '0;
                    if (abort) begin
                        state <= S_IDLE;
                        error <= 1'b1;
                    end else begin
                        word_ptr <= word_ptr + ADDR_W'(1);
                        state    <= (remaining == '0) ? S_DONE : S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (abort) begin
                        error <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ipl_memory_loader.sv
// Directed bench: a cycle table for the streaming, bad-length, abort and abort-vs-WRITE cases,
// then hand sequences for short final word, throttled input with a stray start, wrap and reset mid-load.
module tb_ipl_memory_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [13:0] byte_count;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [15:0] checksum;

    logic        w_in_ready, w_mem_chipselect, w_mem_write, w_cpu_reset_req, w_busy, w_done, w_error;
    logic [11:0] w_mem_address;
    logic [3:0]  w_mem_byteenable;
    logic [31:0] w_mem_writedata;
    logic [15:0] w_checksum;

    always #5 clk = ~clk;

    ipl_memory_loader #(.ADDR_W(12), .BASE_WORD(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_count(byte_count), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .cpu_reset_req(cpu_reset_req),
        .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    ipl_memory_loader #(.ADDR_W(12), .BASE_WORD(4095)) dut_w (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_count(byte_count), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
        .mem_address(w_mem_address), .mem_byteenable(w_mem_byteenable), .mem_chipselect(w_mem_chipselect),
        .mem_write(w_mem_write), .mem_writedata(w_mem_writedata), .cpu_reset_req(w_cpu_reset_req),
        .busy(w_busy), .done(w_done), .error(w_error), .checksum(w_checksum)
    );

    typedef struct packed {
        logic        rdy;
        logic        busy;
        logic        cs;
        logic        wr;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        crr;
        logic        done;
        logic        err;
        logic [15:0] cks;
    } obs_t;

    typedef struct packed {
        logic [2:0]  inp;   // {start, abort, in_valid}
        logic [13:0] bc;
        logic [7:0]  dat;
        obs_t        exp;
    } vec_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    vec_t        vq[$];
    wr_t         wlog[$];
    wr_t         wlogw[$];
    logic [7:0]  img[0:7];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (mem_write) wlog.push_back('{mem_address, mem_writedata, mem_byteenable});
        if (w_mem_write) wlogw.push_back('{w_mem_address, w_mem_writedata, w_mem_byteenable});
        if (done) done_cnt++;
    end

    // flags = {rdy, busy, wr, crr, done, err}; chip select is expected to track the write strobe
    function automatic vec_t mkv(input logic [2:0] inp, input logic [13:0] bc, input logic [7:0] dat,
                                 input logic [5:0] flags, input logic [3:0] be, input logic [11:0] ad,
                                 input logic [31:0] wd, input logic [15:0] ck);
        vec_t v;
        v.inp       = inp;
        v.bc        = bc;
        v.dat       = dat;
        v.exp.rdy   = flags[5];
        v.exp.busy  = flags[4];
        v.exp.wr    = flags[3];
        v.exp.cs    = flags[3];
        v.exp.crr   = flags[2];
        v.exp.done  = flags[1];
        v.exp.err   = flags[0];
        v.exp.be    = be;
        v.exp.addr  = ad;
        v.exp.wdata = wd;
        v.exp.cks   = ck;
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.rdy = in_ready; o.busy = busy; o.cs = mem_chipselect; o.wr = mem_write;
        o.be = mem_byteenable; o.addr = mem_address; o.wdata = mem_writedata;
        o.crr = cpu_reset_req; o.done = done; o.err = error; o.cks = checksum;
        return o;
    endfunction

    task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got rdy=%b busy=%b cs=%b wr=%b be=%h addr=%h wd=%h crr=%b done=%b err=%b cks=%h, expected rdy=%b busy=%b cs=%b wr=%b be=%h addr=%h wd=%h crr=%b done=%b err=%b cks=%h",
                     name, got.rdy, got.busy, got.cs, got.wr, got.be, got.addr, got.wdata, got.crr, got.done, got.err, got.cks,
                     exp.rdy, exp.busy, exp.cs, exp.wr, exp.be, exp.addr, exp.wdata, exp.crr, exp.done, exp.err, exp.cks);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_log(input bit w, input int i, input wr_t exp);
        wr_t got;
        got = '0;
        if (w && wlogw.size() > i) got = wlogw[i];
        if (!w && wlog.size() > i) got = wlog[i];
        chk($sformatf("write%0d%s", i, w ? "_wrap" : ""), 64'(got), 64'(exp));
    endtask

    task automatic kick(input logic [13:0] n);
        start = 1'b1;
        byte_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit rnd, input bit poke);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 500) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = img[idx];
            start    = poke && (cyc == 7);
            if (poke && cyc == 7) byte_count = 14'd5;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("stream_bytes", 64'(idx), 64'(n));
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; byte_count = '0; abort = 1'b0; in_data = '0; in_valid = 1'b0;

        // back-to-back 8-byte image 01..08
        vq.push_back(mkv(3'b100, 14'd8, 8'h00, 6'b000000, 4'h0, 12'h000, 32'h00000000, 16'h0000));
        vq.push_back(mkv(3'b001, 14'd0, 8'h01, 6'b110100, 4'h0, 12'h000, 32'h00000000, 16'h0000));
        vq.push_back(mkv(3'b001, 14'd0, 8'h02, 6'b110100, 4'h0, 12'h000, 32'h00000000, 16'h0001));
        vq.push_back(mkv(3'b001, 14'd0, 8'h03, 6'b110100, 4'h0, 12'h000, 32'h00000000, 16'h0003));
        vq.push_back(mkv(3'b001, 14'd0, 8'h04, 6'b110100, 4'h0, 12'h000, 32'h00000000, 16'h0006));
        vq.push_back(mkv(3'b001, 14'd0, 8'h05, 6'b011100, 4'hF, 12'h000, 32'h04030201, 16'h000A));
        vq.push_back(mkv(3'b001, 14'd0, 8'h05, 6'b110100, 4'h0, 12'h000, 32'h04030201, 16'h000A));
        vq.push_back(mkv(3'b001, 14'd0, 8'h06, 6'b110100, 4'h0, 12'h000, 32'h04030201, 16'h000F));
        vq.push_back(mkv(3'b001, 14'd0, 8'h07, 6'b110100, 4'h0, 12'h000, 32'h04030201, 16'h0015));
        vq.push_back(mkv(3'b001, 14'd0, 8'h08, 6'b110100, 4'h0, 12'h000, 32'h04030201, 16'h001C));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b011100, 4'hF, 12'h001, 32'h08070605, 16'h0024));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b010110, 4'h0, 12'h001, 32'h08070605, 16'h0024));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b000000, 4'h0, 12'h001, 32'h08070605, 16'h0024));
        // zero length: error, stays idle
        vq.push_back(mkv(3'b100, 14'd0, 8'h00, 6'b000000, 4'h0, 12'h001, 32'h08070605, 16'h0024));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0024));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0024));
        // abort after two bytes of an 8-byte load
        vq.push_back(mkv(3'b100, 14'd8, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0024));
        vq.push_back(mkv(3'b001, 14'd0, 8'h11, 6'b110100, 4'h0, 12'h001, 32'h08070605, 16'h0000));
        vq.push_back(mkv(3'b001, 14'd0, 8'h22, 6'b110100, 4'h0, 12'h001, 32'h08070605, 16'h0011));
        vq.push_back(mkv(3'b010, 14'd0, 8'h00, 6'b110100, 4'h0, 12'h001, 32'h08070605, 16'h0033));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0033));
        // largest length the 14-bit port can carry (16383 <= 16384) is accepted
        vq.push_back(mkv(3'b100, 14'd16383, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0033));
        vq.push_back(mkv(3'b010, 14'd0, 8'h00, 6'b110100, 4'h0, 12'h001, 32'h08070605, 16'h0000));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0000));
        // abort in the WRITE cycle wins over the write
        vq.push_back(mkv(3'b100, 14'd1, 8'h00, 6'b000001, 4'h0, 12'h001, 32'h08070605, 16'h0000));
        vq.push_back(mkv(3'b001, 14'd0, 8'h5A, 6'b110100, 4'h0, 12'h001, 32'h08070605, 16'h0000));
        vq.push_back(mkv(3'b010, 14'd0, 8'h00, 6'b010100, 4'h0, 12'h000, 32'h0000005A, 16'h005A));
        vq.push_back(mkv(3'b000, 14'd0, 8'h00, 6'b000001, 4'h0, 12'h000, 32'h0000005A, 16'h005A));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_obs("reset", sample(), '0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (vq[i]) begin
            {start, abort, in_valid} = vq[i].inp;
            byte_count = vq[i].bc;
            in_data    = vq[i].dat;
            @(negedge clk);
            chk_obs($sformatf("vec%0d", i), sample(), vq[i].exp);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;

        chk("table_writes", 64'(wlog.size()), 64'd2);
        chk_log(1'b0, 0, '{12'h000, 32'h04030201, 4'hF});
        chk_log(1'b0, 1, '{12'h001, 32'h08070605, 4'hF});
        chk_log(1'b1, 0, '{12'hFFF, 32'h04030201, 4'hF});
        chk_log(1'b1, 1, '{12'h000, 32'h08070605, 4'hF});

        // 5-byte image: short final word
        wlog.delete(); wlogw.delete(); done_cnt = 0;
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
        kick(14'd5);
        stream(5, 1'b0, 1'b0);
        wait_idle();
        chk("short_nwrites", 64'(wlog.size()), 64'd2);
        chk_log(1'b0, 0, '{12'h000, 32'hDDCCBBAA, 4'hF});
        chk_log(1'b0, 1, '{12'h001, 32'h000000EE, 4'h1});
        chk("short_checksum", 64'(checksum), 64'h03FC);
        chk("short_done", 64'(done_cnt), 64'd1);

        // throttled valid with a stray start mid-load, plus wrap on the high-base instance
        wlog.delete(); wlogw.delete(); done_cnt = 0;
        for (int k = 0; k < 8; k++) img[k] = 8'(k + 1);
        kick(14'd8);
        stream(8, 1'b1, 1'b1);
        wait_idle();
        chk("rnd_nwrites", 64'(wlog.size()), 64'd2);
        chk_log(1'b0, 0, '{12'h000, 32'h04030201, 4'hF});
        chk_log(1'b0, 1, '{12'h001, 32'h08070605, 4'hF});
        chk_log(1'b1, 0, '{12'hFFF, 32'h04030201, 4'hF});
        chk_log(1'b1, 1, '{12'h000, 32'h08070605, 4'hF});
        chk("rnd_checksum", 64'(checksum), 64'h0024);
        chk("rnd_done", 64'(done_cnt), 64'd1);
        chk("rnd_error", 64'(error), 64'd0);

        // reset in the middle of a load
        wlog.delete(); wlogw.delete();
        kick(14'd8);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = img[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_obs("reset_midload", sample(), '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("reset_nwrites", 64'(wlog.size() + wlogw.size()), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
